// File: rtl/core_timer_mc.sv
// Multi-channel machine timer: shared 64-bit mtime with a prescaler, NUM_CH 64-bit compare
// channels with level interrupts, and a high-word snapshot for tear-free 64-bit reads.
module core_timer_mc #(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned PRESC_W        = 8,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter logic [15:0] CTRL_ADDR      = 16'h0000,
  parameter logic [15:0] MTIME_ADDR     = 16'hBFF8,
  parameter logic [15:0] MTIMECMP_ADDR  = 16'h4000
) (
  input  logic                      i_aclk,
  input  logic                      i_aresetn,
  input  logic                      i_valid_reg_write,
  input  logic                      i_valid_reg_read,
  input  logic [15:0]               i_addr,
  input  logic [AXI_DATA_WIDTH-1:0] i_write_data,
  output logic [AXI_DATA_WIDTH-1:0] o_read_data,
  output logic                      o_read_data_valid,
  output logic [63:0]               o_mtime,
  output logic [NUM_CH-1:0]         o_timer_int
);

  logic [63:0]        r_mtime;
  logic [63:0]        r_mtimecmp [NUM_CH];
  logic [PRESC_W-1:0] r_pcnt;
  logic [PRESC_W-1:0] r_presc;
  logic               r_en;
  logic [31:0]        r_hi_snap;
  logic [NUM_CH-1:0]  r_timer_int;

  logic [31:0]        w_wdata;
  logic [31:0]        w_ctrl;
  logic [31:0]        w_rdata;
  logic               w_tick;
  logic               w_wr_ctrl;
  logic               w_wr_mt_lo;
  logic               w_wr_mt_hi;
  logic               w_rd_mt_lo;
  logic [NUM_CH-1:0]  w_wr_cmp_lo;
  logic [NUM_CH-1:0]  w_wr_cmp_hi;

  assign w_wdata    = i_write_data[31:0];
  assign w_tick     = r_en && (r_pcnt == r_presc);
  assign w_wr_ctrl  = i_valid_reg_write && (i_addr == CTRL_ADDR);
  assign w_wr_mt_lo = i_valid_reg_write && (i_addr == MTIME_ADDR);
  assign w_wr_mt_hi = i_valid_reg_write && (i_addr == MTIME_ADDR + 16'd4);
  assign w_rd_mt_lo = i_valid_reg_read && (i_addr == MTIME_ADDR);

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      w_wr_cmp_lo[c] = i_valid_reg_write && (i_addr == 16'(MTIMECMP_ADDR + 16'(8 * c)));
      w_wr_cmp_hi[c] = i_valid_reg_write && (i_addr == 16'(MTIMECMP_ADDR + 16'(8 * c + 4)));
    end
  end

  always_comb begin
    w_ctrl                = '0;
    w_ctrl[0]             = r_en;
    w_ctrl[8 +: PRESC_W]  = r_presc;
  end

  // Reads see register state before any same-cycle write lands.
  always_comb begin
    w_rdata = '0;
    if (i_valid_reg_read) begin
      if (i_addr == CTRL_ADDR) begin
        w_rdata = w_ctrl;
      end else if (i_addr == MTIME_ADDR) begin
        w_rdata = r_mtime[31:0];
      end else if (i_addr == MTIME_ADDR + 16'd4) begin
        w_rdata = r_hi_snap;
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (i_addr == 16'(MTIMECMP_ADDR + 16'(8 * c))) begin
          w_rdata = r_mtimecmp[c][31:0];
        end
        if (i_addr == 16'(MTIMECMP_ADDR + 16'(8 * c + 4))) begin
          w_rdata = r_mtimecmp[c][63:32];
        end
      end
    end
  end

  always_ff @(posedge i_aclk) begin
    if (!i_aresetn) begin
      r_mtime     <= '0;
      r_pcnt      <= '0;
      r_presc     <= '0;
      r_en        <= 1'b1;
      r_hi_snap   <= '0;
      r_timer_int <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_mtimecmp[c] <= '1;
      end
    end else begin
      if (w_wr_ctrl) begin
        r_en    <= w_wdata[0];
        r_presc <= w_wdata[8 +: PRESC_W];
      end

      if (w_wr_ctrl || w_wr_mt_lo || w_wr_mt_hi) begin
        r_pcnt <= '0;
      end else if (r_en) begin
        r_pcnt <= w_tick ? '0 : r_pcnt + PRESC_W'(1);
      end

      // A half-word write suppresses the tick so no carry leaks between halves.
      if (w_wr_mt_lo) begin
        r_mtime[31:0] <= w_wdata;
      end else if (w_wr_mt_hi) begin
        r_mtime[63:32] <= w_wdata;
      end else if (w_tick) begin
        r_mtime <= r_mtime + 64'd1;
      end

      if (w_rd_mt_lo) begin
        r_hi_snap <= r_mtime[63:32];
      end

      for (int c = 0; c < NUM_CH; c++) begin
        if (w_wr_cmp_lo[c]) begin
          r_mtimecmp[c][31:0] <= w_wdata;
        end
        if (w_wr_cmp_hi[c]) begin
          r_mtimecmp[c][63:32] <= w_wdata;
        end
        r_timer_int[c] <= (r_mtime >= r_mtimecmp[c]);
      end
    end
  end

  assign o_read_data       = AXI_DATA_WIDTH'(w_rdata);
  assign o_read_data_valid = i_valid_reg_read;
  assign o_mtime           = r_mtime;
  assign o_timer_int       = r_timer_int;

endmodule

// File: tb/tb_core_timer_mc.sv
// Bench for core_timer_mc: constant vector table, directed multi-cycle sequences and random
// traffic, all compared every cycle against a behavioural model of the timer.
module tb_core_timer_mc;

  localparam int NCH = 4;
  localparam logic [15:0] A_CTRL = 16'h0000;
  localparam logic [15:0] A_MTL  = 16'hBFF8;
  localparam logic [15:0] A_MTH  = 16'hBFFC;
  localparam logic [15:0] A_CMP  = 16'h4000;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            we;
  logic            re;
  logic [15:0]     addr;
  logic [31:0]     wdata;
  logic [31:0]     rdata;
  logic            rvalid;
  logic [63:0]     mtime;
  logic [NCH-1:0]  tint;

  always #5 clk = ~clk;

  core_timer_mc #(.NUM_CH(NCH)) dut (
    .i_aclk            (clk),
    .i_aresetn         (rst_n),
    .i_valid_reg_write (we),
    .i_valid_reg_read  (re),
    .i_addr            (addr),
    .i_write_data      (wdata),
    .o_read_data       (rdata),
    .o_read_data_valid (rvalid),
    .o_mtime           (mtime),
    .o_timer_int       (tint)
  );

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: m_since counts enabled cycles since the last prescaler clear.
  logic [63:0]    m_mtime;
  logic [63:0]    m_cmp [NCH];
  logic           m_en;
  int unsigned    m_presc;
  int unsigned    m_since;
  logic [31:0]    m_snap;
  logic [NCH-1:0] m_int;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mtime = '0;
    m_en    = 1'b1;
    m_presc = 0;
    m_since = 0;
    m_snap  = '0;
    m_int   = '0;
    for (int c = 0; c < NCH; c++) m_cmp[c] = '1;
  endtask

  function automatic logic [31:0] model_read(input logic [15:0] a);
    logic [31:0] v;
    v = 32'h0;
    if (a == A_CTRL) v = (m_presc << 8) | 32'(m_en);
    else if (a == A_MTL) v = m_mtime[31:0];
    else if (a == A_MTH) v = m_snap;
    else begin
      for (int c = 0; c < NCH; c++) begin
        if (a == A_CMP + 16'(8 * c)) v = m_cmp[c][31:0];
        if (a == A_CMP + 16'(8 * c + 4)) v = m_cmp[c][63:32];
      end
    end
    return v;
  endfunction

  task automatic model_step(input logic r, input logic w, input logic rd,
                            input logic [15:0] a, input logic [31:0] d);
    logic [NCH-1:0] nint;
    logic           tick;
    logic [63:0]    old_mt;
    if (!r) begin
      model_reset();
      return;
    end
    old_mt = m_mtime;
    for (int c = 0; c < NCH; c++) nint[c] = (m_mtime >= m_cmp[c]);
    tick = m_en && (((m_since + 1) % (m_presc + 1)) == 0);
    if (w && (a == A_MTL || a == A_MTH)) begin
      if (a == A_MTL) m_mtime[31:0] = d;
      else m_mtime[63:32] = d;
      m_since = 0;
    end else begin
      if (tick) m_mtime = m_mtime + 64'd1;
      if (m_en) m_since = m_since + 1;
    end
    if (w && a == A_CTRL) begin
      m_en    = d[0];
      m_presc = int'(d[15:8]);
      m_since = 0;
    end
    if (rd && a == A_MTL) m_snap = old_mt[63:32];
    if (w) begin
      for (int c = 0; c < NCH; c++) begin
        if (a == A_CMP + 16'(8 * c)) m_cmp[c][31:0] = d;
        if (a == A_CMP + 16'(8 * c + 4)) m_cmp[c][63:32] = d;
      end
    end
    m_int = nint;
  endtask

  // Entered 1 time unit after a rising edge; samples on the falling edge.
  task automatic cycle(input logic r, input logic w, input logic rd, input logic [15:0] a,
                       input logic [31:0] d, output logic [31:0] got);
    rst_n = r; we = w; re = rd; addr = a; wdata = d;
    #4;
    got = rdata;
    check("rvalid", 64'(rvalid), 64'(rd));
    check("rdata", 64'(rdata), 64'(rd ? model_read(a) : 32'h0));
    check("mtime", mtime, m_mtime);
    check("timer_int", 64'(tint), 64'(m_int));
    model_step(r, w, rd, a, d);
    @(posedge clk);
    #1;
    rst_n = 1'b1; we = 1'b0; re = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic        re;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;

  localparam int NV = 23;

  initial begin
    vec_t        tbl [NV];
    logic [15:0] alist [12];
    logic [31:0] got;
    int          ok;
    int          sel;
    logic [31:0] d;

    tbl[0]  = '{1'b0, 1'b1, A_CTRL,    32'h0,         32'h1};
    tbl[1]  = '{1'b0, 1'b1, 16'h4000,  32'h0,         32'hFFFF_FFFF};
    tbl[2]  = '{1'b0, 1'b1, 16'h4004,  32'h0,         32'hFFFF_FFFF};
    tbl[3]  = '{1'b0, 1'b1, 16'h401C,  32'h0,         32'hFFFF_FFFF};
    tbl[4]  = '{1'b0, 1'b1, 16'h4020,  32'h0,         32'h0};
    tbl[5]  = '{1'b0, 1'b1, 16'h0004,  32'h0,         32'h0};
    tbl[6]  = '{1'b0, 1'b1, A_MTH,     32'h0,         32'h0};
    tbl[7]  = '{1'b1, 1'b0, A_CTRL,    32'h0,         32'h0};
    tbl[8]  = '{1'b0, 1'b1, A_CTRL,    32'h0,         32'h0};
    tbl[9]  = '{1'b1, 1'b0, A_MTL,     32'hAAAA_5555, 32'h0};
    tbl[10] = '{1'b0, 1'b1, A_MTL,     32'h0,         32'hAAAA_5555};
    tbl[11] = '{1'b1, 1'b0, A_MTH,     32'h1234_5678, 32'h0};
    tbl[12] = '{1'b0, 1'b1, A_MTH,     32'h0,         32'h0};
    tbl[13] = '{1'b0, 1'b1, A_MTL,     32'h0,         32'hAAAA_5555};
    tbl[14] = '{1'b0, 1'b1, A_MTH,     32'h0,         32'h1234_5678};
    tbl[15] = '{1'b1, 1'b0, 16'h4010,  32'hCAFE,      32'h0};
    tbl[16] = '{1'b1, 1'b1, 16'h4010,  32'hBEEF,      32'hCAFE};
    tbl[17] = '{1'b0, 1'b1, 16'h4010,  32'h0,         32'hBEEF};
    tbl[18] = '{1'b1, 1'b0, 16'h4020,  32'h1,         32'h0};
    tbl[19] = '{1'b0, 1'b1, 16'h4020,  32'h0,         32'h0};
    tbl[20] = '{1'b1, 1'b0, A_CTRL,    32'hFFFF_0200, 32'h0};
    tbl[21] = '{1'b0, 1'b1, A_CTRL,    32'h0,         32'h200};
    tbl[22] = '{1'b0, 1'b1, 16'h4014,  32'h0,         32'hFFFF_FFFF};

    alist = '{A_CTRL, A_MTL, A_MTH, 16'h4000, 16'h4004, 16'h4008, 16'h400C,
              16'h4010, 16'h401C, 16'h4020, 16'h4024, 16'h0004};

    rst_n = 1'b0; we = 1'b0; re = 1'b0; addr = '0; wdata = '0;
    @(posedge clk);
    #1;
    model_reset();

    for (int i = 0; i < NV; i++) begin
      cycle(1'b1, tbl[i].we, tbl[i].re, tbl[i].addr, tbl[i].wdata, got);
      if (tbl[i].re) check($sformatf("tbl%0d", i), 64'(got), 64'(tbl[i].exp_rd));
    end

    // Free-running count from reset
    cycle(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, got);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b0, 16'h0, 32'h0, got);
    check("t1_mtime10", mtime, 64'd10);
    check("t1_int0", 64'(tint), 64'd0);

    // Prescaler 3: one tick per 4 cycles, then frozen
    cycle(1'b1, 1'b1, 1'b0, A_CTRL, 32'h0301, got);
    check("t2_ctrl_cycle", mtime, 64'd11);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 16'h0, 32'h0, got);
    check("t2_no_tick_yet", mtime, 64'd11);
    cycle(1'b1, 1'b0, 1'b0, 16'h0, 32'h0, got);
    check("t2_tick4", mtime, 64'd12);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 16'h0, 32'h0, got);
    check("t2_tick8", mtime, 64'd13);
    cycle(1'b1, 1'b1, 1'b0, A_CTRL, 32'h0, got);
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 1'b0, 16'h0, 32'h0, got);
    check("t2_frozen", mtime, 64'd13);

    // Channel 1 compare at 50, then raised to 100
    cycle(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, got);
    cycle(1'b1, 1'b1, 1'b0, 16'h4008, 32'd50, got);
    cycle(1'b1, 1'b1, 1'b0, 16'h400C, 32'd0, got);
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      if (mtime == 64'd50) begin
        ok = 1;
        break;
      end
      cycle(1'b1, 1'b0, 1'b0, 16'h0, 32'h0, got);
    end
    check("t3_reach50", 64'(ok), 64'd1);
    check("t3_int_not_yet", 64'(tint), 64'd0);
    cycle(1'b1, 1'b0, 1'b0, 16'h0, 32'h0, got);
    check("t3_int1_rise", 64'(tint), 64'b0010);
    cycle(1'b1, 1'b1, 1'b0, 16'h4008, 32'd100, got);
    check("t3_int1_hold", 64'(tint), 64'b0010);
    cycle(1'b1, 1'b0, 1'b0, 16'h0, 32'h0, got);
    check("t3_int1_drop", 64'(tint), 64'd0);

    // Wrap at 2^64
    cycle(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, got);
    cycle(1'b1, 1'b1, 1'b0, A_MTL, 32'hFFFF_FFFE, got);
    cycle(1'b1, 1'b1, 1'b0, A_MTH, 32'hFFFF_FFFF, got);
    check("t4_written", mtime, 64'hFFFF_FFFF_FFFF_FFFE);
    cycle(1'b1, 1'b0, 1'b0, 16'h0, 32'h0, got);
    check("t4_max", mtime, 64'hFFFF_FFFF_FFFF_FFFF);
    check("t4_int_low", 64'(tint), 64'd0);
    cycle(1'b1, 1'b0, 1'b0, 16'h0, 32'h0, got);
    check("t4_wrap", mtime, 64'd0);
    check("t4_int_all", 64'(tint), 64'b1111);
    cycle(1'b1, 1'b0, 1'b0, 16'h0, 32'h0, got);
    check("t4_int_clear", 64'(tint), 64'd0);

    // Snapshot keeps the high word seen at the low read
    cycle(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, got);
    cycle(1'b1, 1'b1, 1'b0, A_MTL, 32'hFFFF_FFFF, got);
    cycle(1'b1, 1'b1, 1'b0, A_MTH, 32'd5, got);
    cycle(1'b1, 1'b0, 1'b1, A_MTL, 32'h0, got);
    check("t5_read_lo", 64'(got), 64'hFFFF_FFFF);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 16'h0, 32'h0, got);
    cycle(1'b1, 1'b0, 1'b1, A_MTH, 32'h0, got);
    check("t5_read_hi_snap", 64'(got), 64'd5);
    check("t5_live_hi", 64'(mtime[63:32]), 64'd6);

    // Reset while counting with an active interrupt
    cycle(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, got);
    cycle(1'b1, 1'b1, 1'b0, 16'h4000, 32'd3, got);
    cycle(1'b1, 1'b1, 1'b0, 16'h4004, 32'd0, got);
    cycle(1'b1, 1'b1, 1'b0, A_CTRL, 32'h0101, got);
    ok = 0;
    for (int k = 0; k < 50; k++) begin
      if (tint[0]) begin
        ok = 1;
        break;
      end
      cycle(1'b1, 1'b0, 1'b0, 16'h0, 32'h0, got);
    end
    check("t6_int_active", 64'(ok), 64'd1);
    cycle(1'b1, 1'b0, 1'b1, A_MTL, 32'h0, got);
    cycle(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, got);
    check("t6_mtime0", mtime, 64'd0);
    check("t6_int0", 64'(tint), 64'd0);
    cycle(1'b1, 1'b0, 1'b1, A_CTRL, 32'h0, got);
    check("t6_ctrl", 64'(got), 64'h1);
    cycle(1'b1, 1'b0, 1'b1, 16'h4000, 32'h0, got);
    check("t6_cmp0", 64'(got), 64'hFFFF_FFFF);
    cycle(1'b1, 1'b0, 1'b1, A_MTH, 32'h0, got);
    check("t6_snap", 64'(got), 64'd0);
    cycle(1'b1, 1'b0, 1'b1, 16'h4040, 32'h0, got);
    check("t6_unmapped", 64'(got), 64'd0);

    // Random traffic against the model
    for (int i = 0; i < 2000; i++) begin
      sel = $urandom_range(0, 99);
      if (sel < 40) begin
        cycle(1'b1, 1'b0, 1'b0, 16'h0, 32'h0, got);
      end else if (sel < 55) begin
        cycle(1'b1, 1'b0, 1'b1, alist[$urandom_range(0, 11)], 32'h0, got);
      end else if (sel < 63) begin
        d = m_mtime[31:0] + $urandom_range(0, 40);
        cycle(1'b1, 1'b1, 1'b0, A_CMP + 16'(8 * $urandom_range(0, NCH - 1)), d, got);
      end else if (sel < 66) begin
        d = m_mtime[63:32] + $urandom_range(0, 1);
        cycle(1'b1, 1'b1, 1'b0, A_CMP + 16'(8 * $urandom_range(0, NCH - 1) + 4), d, got);
      end else if (sel < 72) begin
        d = {16'($urandom), 8'($urandom_range(0, 3)), 7'($urandom),
             1'($urandom_range(0, 5) != 0)};
        cycle(1'b1, 1'b1, 1'b0, A_CTRL, d, got);
      end else if (sel < 76) begin
        d = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFF0 + $urandom_range(0, 15) : $urandom;
        cycle(1'b1, 1'b1, 1'b0, A_MTL, d, got);
      end else if (sel < 79) begin
        d = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 3));
        cycle(1'b1, 1'b1, 1'b0, A_MTH, d, got);
      end else if (sel < 80) begin
        cycle(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, got);
      end else begin
        cycle(1'b1, 1'b1, 1'b1, alist[$urandom_range(0, 11)], $urandom, got);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
